fclk_align: RTL and testbench

Parametrised frame-clock alignment controller for the ADC deserialiser path. It runs in the parallel (divclk) domain and watches the deserialised ADC frame-clock word. It drives the shared ISERDES2 `bitslip` strobe until the word matches the expected frame pattern, then declares lock. It keeps monitoring after lock, counts frame errors, and re-aligns automatically on loss of lock. The `bitslip` output fans out to the frame lane and to every data lane, so all lanes slip together.

---
 rtl/serdes_pkg.sv | 26 ++
 rtl/fclk_align_if.sv | 35 +++
 rtl/sat_counter.sv | 22 ++
 rtl/fclk_align.sv | 158 +++++++++++++++
 tb/tb_fclk_align.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the ADC deserialiser path: the alignment FSM state
// encoding and the default frame-clock pattern for each deserialisation ratio.
package serdes_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_CONFIRM,
        ST_LOCKED,
        ST_FAIL
    } align_state_t;

    // The frame clock is high for the upper half of the word, e.g. 8'hF0 at 1:8.
    function automatic logic [7:0] default_frame_pattern(input int width);
        logic [7:0] pattern;
        pattern = '0;
        for (int i = 0; i < 8; i++) begin
            if ((i >= width / 2) && (i < width)) begin
                pattern[i] = 1'b1;
            end
        end
        return pattern;
    endfunction

endpackage

// File: rtl/fclk_align_if.sv
// Frame-alignment bundle between the deserialised frame lane and the
// alignment controller; slave is the controller side.
interface fclk_align_if #(
    parameter int DESER_WIDTH = 8
);

    logic [DESER_WIDTH-1:0]         fclk_deser;
    logic                           realign;
    logic                           bitslip;
    logic                           locked;
    logic                           align_fail;
    logic [$clog2(DESER_WIDTH)-1:0] slip_count;
    logic [15:0]                    err_count;

    modport master (
        output fclk_deser,
        output realign,
        input  bitslip,
        input  locked,
        input  align_fail,
        input  slip_count,
        input  err_count
    );

    modport slave (
        input  fclk_deser,
        input  realign,
        output bitslip,
        output locked,
        output align_fail,
        output slip_count,
        output err_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fclk_align.sv
// Frame-clock alignment controller: slips all ISERDES2 lanes together until the
// frame word matches, holds lock while monitoring, and re-aligns on loss of lock.
module fclk_align
    import serdes_pkg::*;
#(
    parameter int                     DESER_WIDTH   = 8,
    parameter logic [DESER_WIDTH-1:0] FRAME_PATTERN = DESER_WIDTH'(default_frame_pattern(DESER_WIDTH)),
    parameter int                     SETTLE_CYCLES = 4,
    parameter int                     LOCK_COUNT    = 16,
    parameter int                     LOSS_COUNT    = 4
) (
    input  logic         divclk,
    input  logic         rst,
    fclk_align_if.slave  bus
);

    localparam int SW  = $clog2(DESER_WIDTH);
    localparam int STW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW  = $clog2(LOCK_COUNT + 1);
    localparam int LW  = $clog2(LOSS_COUNT + 1);

    localparam logic [SW-1:0]  SLIP_MAX    = SW'(DESER_WIDTH - 1);
    localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0]  LOCK_LAST   = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0]  LOSS_LAST   = LW'(LOSS_COUNT - 1);

    align_state_t   state, next_state;
    logic [STW-1:0] settle_cnt, settle_nxt;
    logic [MW-1:0]  match_cnt, match_nxt;
    logic [LW-1:0]  miss_cnt, miss_nxt;
    logic [SW-1:0]  slip_cnt, slip_nxt;
    logic           bitslip_q, locked_q, align_fail_q;
    logic           frame_match;
    logic           err_inc;

    assign frame_match = (bus.fclk_deser == FRAME_PATTERN);
    assign err_inc     = (state == ST_LOCKED) && !frame_match;

    assign bus.bitslip    = bitslip_q;
    assign bus.locked     = locked_q;
    assign bus.align_fail = align_fail_q;
    assign bus.slip_count = slip_cnt;

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge divclk or posedge rst) begin
        if (rst) begin
            state        <= ST_SETTLE;
            settle_cnt   <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            slip_cnt     <= '0;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
            align_fail_q <= 1'b0;
        end else begin
            state        <= next_state;
            settle_cnt   <= settle_nxt;
            match_cnt    <= match_nxt;
            miss_cnt     <= miss_nxt;
            slip_cnt     <= slip_nxt;
            bitslip_q    <= (next_state == ST_SLIP);
            locked_q     <= (next_state == ST_LOCKED);
            align_fail_q <= (next_state == ST_FAIL);
        end
    end

    always_comb begin
        next_state = state;
        settle_nxt = settle_cnt;
        match_nxt  = match_cnt;
        miss_nxt   = miss_cnt;
        slip_nxt   = slip_cnt;

        case (state)
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_CHECK;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                if (frame_match) begin
                    if (LOCK_COUNT == 1) begin
                        next_state = ST_LOCKED;
                    end else begin
                        next_state = ST_CONFIRM;
                        match_nxt  = MW'(1);
                    end
                end else if (slip_cnt == SLIP_MAX) begin
                    next_state = ST_FAIL;
                end else begin
                    next_state = ST_SLIP;
                    slip_nxt   = slip_cnt + 1'b1;
                end
            end
            ST_SLIP: begin
                next_state = ST_SETTLE;
            end
            ST_CONFIRM: begin
                if (frame_match) begin
                    if (match_cnt == LOCK_LAST) begin
                        next_state = ST_LOCKED;
                        match_nxt  = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end else begin
                    match_nxt = '0;
                    if (slip_cnt == SLIP_MAX) begin
                        next_state = ST_FAIL;
                    end else begin
                        next_state = ST_SLIP;
                        slip_nxt   = slip_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_match) begin
                    miss_nxt = '0;
                end else if (miss_cnt == LOSS_LAST) begin
                    next_state = ST_SETTLE;
                    miss_nxt   = '0;
                    slip_nxt   = '0;
                end else begin
                    miss_nxt = miss_cnt + 1'b1;
                end
            end
            ST_FAIL: begin
                next_state = ST_FAIL;
            end
            default: begin
                next_state = ST_SETTLE;
            end
        endcase

        // A realign request overrides everything, including a pending slip.
        if (bus.realign) begin
            next_state = ST_SETTLE;
            settle_nxt = '0;
            match_nxt  = '0;
            miss_nxt   = '0;
            slip_nxt   = '0;
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_err_count (
        .clk   (divclk),
        .rst   (rst),
        .clear (bus.realign),
        .inc   (err_inc),
        .count (bus.err_count)
    );

endmodule

// File: tb/tb_fclk_align.sv
// Directed bench for fclk_align: lock latency, slip search against a rotating
// ISERDES model, failure, loss of lock, realign/reset priority and err saturation.
module tb_fclk_align;

    logic       divclk;
    logic       rst;
    logic [7:0] base_word;
    logic [7:0] direct_word;
    logic [7:0] sat_word;
    logic       use_model;
    int         slips_seen;
    int         cyc;
    int         last_slip_cyc;
    int         gap_bad;
    int         width_bad;
    int         excl_bad;
    logic       bitslip_prev;
    int         checks;
    int         errors;
    int         mism;

    fclk_align_if #(.DESER_WIDTH(8)) bus ();
    fclk_align_if #(.DESER_WIDTH(8)) sat_bus ();

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n % 8; i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    // Each bitslip seen by the lanes rotates the incoming frame word by one bit.
    assign bus.fclk_deser     = use_model ? rotl8(base_word, slips_seen) : direct_word;
    assign sat_bus.fclk_deser = sat_word;

    fclk_align #(
        .DESER_WIDTH   (8),
        .FRAME_PATTERN (8'hF0),
        .SETTLE_CYCLES (4),
        .LOCK_COUNT    (16),
        .LOSS_COUNT    (4)
    ) dut (
        .divclk (divclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    fclk_align #(
        .DESER_WIDTH   (8),
        .FRAME_PATTERN (8'hF0),
        .SETTLE_CYCLES (4),
        .LOCK_COUNT    (16),
        .LOSS_COUNT    (1024)
    ) dut_sat (
        .divclk (divclk),
        .rst    (rst),
        .bus    (sat_bus.slave)
    );

    initial divclk = 1'b0;
    always #5 divclk = ~divclk;

    always @(posedge divclk) begin
        if (rst) begin
            slips_seen    <= 0;
            last_slip_cyc <= -100;
            gap_bad       <= 0;
            width_bad     <= 0;
            bitslip_prev  <= 1'b0;
        end else begin
            bitslip_prev <= bus.bitslip;
            if (bus.bitslip) begin
                slips_seen    <= slips_seen + 1;
                last_slip_cyc <= cyc;
                if (bitslip_prev) width_bad <= width_bad + 1;
                if (cyc - last_slip_cyc < 6) gap_bad <= gap_bad + 1;
            end
            if (bus.locked && bus.align_fail) excl_bad <= excl_bad + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic realign_val);
        direct_word = word;
        bus.realign = realign_val;
        @(posedge divclk);
        #1;
        bus.realign = 1'b0;
    endtask

    task automatic runCycles(input int n, input logic [7:0] word);
        repeat (n) applyStimulus(word, 1'b0);
    endtask

    task automatic driveSat(input logic [7:0] word, input logic realign_val);
        sat_word        = word;
        sat_bus.realign = realign_val;
        @(posedge divclk);
        #1;
        sat_bus.realign = 1'b0;
    endtask

    task automatic resetDut(input logic model, input logic [7:0] word);
        rst             = 1'b1;
        use_model       = model;
        base_word       = word;
        direct_word     = word;
        bus.realign     = 1'b0;
        sat_bus.realign = 1'b0;
        repeat (2) @(posedge divclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $finish;
    end

    initial begin
        checks          = 0;
        errors          = 0;
        excl_bad        = 0;
        rst             = 1'b1;
        use_model       = 1'b0;
        base_word       = 8'h00;
        direct_word     = 8'hF0;
        sat_word        = 8'hF0;
        bus.realign     = 1'b0;
        sat_bus.realign = 1'b0;
        @(posedge divclk);
        #1;
        checkOutput("rst_locked", 32'(bus.locked), 0);
        checkOutput("rst_bitslip", 32'(bus.bitslip), 0);
        checkOutput("rst_align_fail", 32'(bus.align_fail), 0);
        checkOutput("rst_slip_count", 32'(bus.slip_count), 0);
        checkOutput("rst_err_count", 32'(bus.err_count), 0);

        $display("[TB] aligned from the start");
        resetDut(1'b0, 8'hF0);
        runCycles(19, 8'hF0);
        checkOutput("lock_early", 32'(bus.locked), 0);
        runCycles(1, 8'hF0);
        checkOutput("lock_latency", 32'(bus.locked), 1);
        checkOutput("t1_no_slip", 32'(slips_seen), 0);
        checkOutput("t1_slip_count", 32'(bus.slip_count), 0);

        $display("[TB] error bursts while locked");
        for (int b = 0; b < 2; b++) begin
            runCycles(3, 8'h00);
            runCycles(1, 8'hF0);
            checkOutput("burst_locked", 32'(bus.locked), 1);
            checkOutput("burst_err", 32'(bus.err_count), 32'(3 * (b + 1)));
        end
        runCycles(3, 8'h00);
        checkOutput("loss_third", 32'(bus.locked), 1);
        runCycles(1, 8'h00);
        checkOutput("loss_fourth", 32'(bus.locked), 0);
        checkOutput("loss_err_kept", 32'(bus.err_count), 10);
        runCycles(19, 8'hF0);
        checkOutput("relock_early", 32'(bus.locked), 0);
        runCycles(1, 8'hF0);
        checkOutput("relock", 32'(bus.locked), 1);
        checkOutput("relock_err_kept", 32'(bus.err_count), 10);
        applyStimulus(8'hF0, 1'b1);
        checkOutput("realign_err_clear", 32'(bus.err_count), 0);
        checkOutput("realign_unlock", 32'(bus.locked), 0);

        $display("[TB] three slips needed");
        resetDut(1'b1, 8'h1E);
        runCycles(37, 8'h1E);
        checkOutput("slip3_lock_early", 32'(bus.locked), 0);
        runCycles(1, 8'h1E);
        checkOutput("slip3_locked", 32'(bus.locked), 1);
        checkOutput("slip3_pulses", 32'(slips_seen), 3);
        checkOutput("slip3_slip_count", 32'(bus.slip_count), 3);
        checkOutput("slip3_gap", 32'(gap_bad), 0);
        checkOutput("slip3_width", 32'(width_bad), 0);

        $display("[TB] pattern never matches");
        resetDut(1'b0, 8'h00);
        runCycles(46, 8'h00);
        checkOutput("fail_early", 32'(bus.align_fail), 0);
        runCycles(1, 8'h00);
        checkOutput("fail_time", 32'(bus.align_fail), 1);
        checkOutput("fail_slip_count", 32'(bus.slip_count), 7);
        checkOutput("fail_pulses", 32'(slips_seen), 7);
        runCycles(5, 8'h00);
        checkOutput("fail_hold", 32'(bus.align_fail), 1);
        checkOutput("fail_unlocked", 32'(bus.locked), 0);
        checkOutput("fail_no_slip", 32'(slips_seen), 7);
        applyStimulus(8'hF0, 1'b1);
        checkOutput("realign_clear_fail", 32'(bus.align_fail), 0);
        checkOutput("realign_clear_slips", 32'(bus.slip_count), 0);
        runCycles(19, 8'hF0);
        checkOutput("fail_relock_early", 32'(bus.locked), 0);
        runCycles(1, 8'hF0);
        checkOutput("fail_relock", 32'(bus.locked), 1);

        $display("[TB] realign on the would-be slip cycle");
        resetDut(1'b1, 8'h1E);
        runCycles(4, 8'h1E);
        applyStimulus(8'h1E, 1'b1);
        checkOutput("realign_no_slip", 32'(bus.bitslip), 0);
        checkOutput("realign_slip_count", 32'(bus.slip_count), 0);
        runCycles(1, 8'h1E);
        checkOutput("realign_still_no_slip", 32'(bus.bitslip), 0);
        checkOutput("realign_pulses", 32'(slips_seen), 0);
        runCycles(36, 8'h1E);
        checkOutput("realign_lock_early", 32'(bus.locked), 0);
        runCycles(1, 8'h1E);
        checkOutput("realign_relock", 32'(bus.locked), 1);
        checkOutput("realign_relock_pulses", 32'(slips_seen), 3);

        $display("[TB] reset during slip");
        resetDut(1'b1, 8'h1E);
        runCycles(5, 8'h1E);
        checkOutput("slip_pulse_high", 32'(bus.bitslip), 1);
        checkOutput("slip_pulse_count", 32'(bus.slip_count), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_slip", 32'(bus.bitslip), 0);
        checkOutput("rst_clears_slips", 32'(bus.slip_count), 0);
        @(posedge divclk);
        #1;
        rst = 1'b0;
        runCycles(37, 8'h1E);
        checkOutput("rst_lock_early", 32'(bus.locked), 0);
        runCycles(1, 8'h1E);
        checkOutput("rst_relock", 32'(bus.locked), 1);
        checkOutput("rst_relock_pulses", 32'(slips_seen), 3);

        $display("[TB] err_count saturation");
        driveSat(8'hF0, 1'b1);
        repeat (20) driveSat(8'hF0, 1'b0);
        checkOutput("sat_locked", 32'(sat_bus.locked), 1);
        checkOutput("sat_err_start", 32'(sat_bus.err_count), 0);
        mism = 0;
        for (int blk = 0; blk < 66; blk++) begin
            for (int k = 0; k < 1000; k++) begin
                driveSat(8'h00, 1'b0);
                mism++;
                if (mism == 65534) checkOutput("sat_below", 32'(sat_bus.err_count), 32'hFFFE);
                if (mism == 65535) checkOutput("sat_reach", 32'(sat_bus.err_count), 32'hFFFF);
            end
            driveSat(8'hF0, 1'b0);
        end
        checkOutput("sat_hold", 32'(sat_bus.err_count), 32'hFFFF);
        checkOutput("sat_still_locked", 32'(sat_bus.locked), 1);

        checkOutput("locked_fail_exclusive", 32'(excl_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
